id_issue_stage: RTL and testbench
=================================

// Module: id_issue_stage
// PURPOSE
//  Parametrised decode/issue stage. Decodes the logic/shift/immediate subset, reads operands and
//  forwards from NUM_FWD downstream producers (index 0 = youngest). Detects load-use hazards and
//  stalls. Registers results into an ID/EX output register with valid/ready handshake and flush.
//  Sits between the IF/ID register and ex; drives the regfile read ports.
// PARAMETERS
//  DATA_W   32  operand/result width
//  ADDR_W   5   register address width
//  NUM_FWD  2   number of forwarding sources (>=1), packed LSB-first, index 0 highest priority
//  CNT_W    16  width of stall performance counter
// PORTS
//  clk          in   1                clock
//  rst          in   1                reset
//  in_valid     in   1                pc_i/inst_i valid
//  in_ready     out  1                stage accepts current instruction this cycle
//  pc_i         in   32               instruction address
//  inst_i       in   32               instruction word
//  reg1_read_o  out  1                regfile port 1 enable (combinational)
//  reg2_read_o  out  1                regfile port 2 enable (combinational)
//  reg1_addr_o  out  ADDR_W           rs (combinational)
//  reg2_addr_o  out  ADDR_W           rt (combinational)
//  reg1_data_i  in   DATA_W           regfile port 1 data, same cycle
//  reg2_data_i  in   DATA_W           regfile port 2 data, same cycle
//  fwd_wreg_i   in   NUM_FWD          source k writes a register
//  fwd_wd_i     in   NUM_FWD*ADDR_W   source k destination
//  fwd_wdata_i  in   NUM_FWD*DATA_W   source k result
//  fwd_pend_i   in   NUM_FWD          source k result not yet available (load in flight)
//  flush_i      in   1                kill output register and current input
//  out_valid    out  1                ID/EX register holds an instruction
//  out_ready    in   1                ex consumes the register this cycle
//  aluop_o      out  8                `EXE_*_OP code
//  alusel_o     out  3                `EXE_RES_* code
//  reg1_o       out  DATA_W           operand 1
//  reg2_o       out  DATA_W           operand 2
//  wd_o         out  ADDR_W           destination register
//  wreg_o       out  1                write enable
//  pc_o         out  32               pc of issued instruction
//  instvalid_o  out  1                1 = recognised opcode
//  stall_cnt_o  out  CNT_W            cycles stalled on hazards, saturating
// BEHAVIOUR
//  Reset rst: synchronous, active-high. On reset: out_valid=0, aluop_o=`EXE_NOP_OP, alusel_o=`EXE_RES_NOP,
//   reg1_o=reg2_o=0, wd_o=0, wreg_o=0, pc_o=0, instvalid_o=0, stall_cnt_o=0.
//  Decode: OR/AND/XOR/NOR, SLLV/SRLV/SRAV (rs,rt -> rd); ORI/ANDI/XORI zero-ext imm, LUI {imm,16'h0} (rs,imm -> rt);
//   SLL/SRL/SRA require inst[31:21]==0, operand1=shamt zero-extended, operand2=rt, dest rd; PREF = NOP, valid.
//   Any other word: instvalid_o=0, wreg_o=0, aluop NOP; still issued (exceptions handled later).
//  Operand select per port p (when read enabled): addr==0 -> 0; else lowest k with fwd_wreg_i[k] && fwd_wd_i[k]==addr
//   supplies fwd_wdata_i[k]; no match -> regfile data. Port not read -> immediate.
//  Hazard: stall = in_valid && read port p enabled && selected source k has fwd_pend_i[k]=1. Younger
//   non-pending match shadows an older pending one (no stall).
//  in_ready = flush_i | (!stall & (!out_valid | out_ready)). Combinational, no dependence on itself.
//  Register update, priority order: flush_i -> out_valid<=0 (input dropped); else if (!out_valid|out_ready):
//   load decoded fields and out_valid<=in_valid&!stall (stall inserts bubble); else hold all outputs.
//  Latency 1 cycle from acceptance to out_valid. Outputs stable while out_valid&!out_ready.
//  stall_cnt_o += 1 each cycle stall=1 and !flush_i; saturates at all-ones; cleared only by rst.
//  rst wins over flush_i and handshake; in-flight instruction discarded.
// TESTING
//  ORI r2,r0,0x1234, no fwd -> next cycle out_valid=1, reg1_o=0, reg2_o=0x00001234, wd_o=2, wreg_o=1, aluop OR.
//  OR r5,r3,r4 with fwd0 r3=0xA, fwd1 r3=0xB, fwd1 r4=0xC -> reg1_o=0xA, reg2_o=0xC.
//  fwd0 r3 pend=1 for 2 cycles, then pend=0 data 0x77 -> in_ready=0 2 cycles, bubble, then reg1_o=0x77, stall_cnt_o=2.
//  fwd0 writes r0=0xFF, instr reads r0 -> reg1_o=0; SLL r1,r2,5 -> reg1_o=5, reg2_o=rt value.
//  out_ready=0 for 3 cycles with out_valid=1 -> all outputs unchanged, in_ready=0; release -> next instr loads.
//  flush_i during stall -> out_valid=0 next cycle, in_ready=1, stall_cnt_o not incremented; rst mid-stream -> reset values.

Source files
------------

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage with multi-source forwarding, load-use stall and ID/EX handshake register
module id_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [ADDR_W-1:0]         reg1_addr_o,
  output logic [ADDR_W-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_pend_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [ADDR_W-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [31:0]               pc_o,
  output logic                      instvalid_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);
  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03, OP_SLLV = 8'h04, OP_SRLV = 8'h06, OP_SRAV = 8'h07;
  localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2;
  logic [5:0] op, funct;
  logic [7:0] aluop;
  logic [2:0] alusel;
  logic [ADDR_W-1:0] wd;
  logic [DATA_W-1:0] imm;
  logic wreg, iv, stall;
  logic [1:0] rd_en, pend;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] rdata, opnd;
  assign op = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign addr = {ADDR_W'(inst_i[20:16]), ADDR_W'(inst_i[25:21])};
  assign rdata = {reg2_data_i, reg1_data_i};
  assign {reg2_read_o, reg1_read_o} = rd_en;
  assign reg1_addr_o = addr[0];
  assign reg2_addr_o = addr[1];
  always_comb begin
    aluop = OP_NOP;
    alusel = RES_NOP;
    rd_en = 2'b00;
    wreg = 1'b0;
    wd = ADDR_W'(inst_i[15:11]);
    imm = '0;
    iv = 1'b0;
    case (op)
      6'b000000: case (funct)
        6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
          aluop = {2'b00, funct};
          alusel = RES_LOGIC;
          rd_en = 2'b11;
          wreg = 1'b1;
          iv = 1'b1;
        end
        6'b000100, 6'b000110, 6'b000111: begin
          aluop = funct == 6'b000100 ? OP_SLLV : funct == 6'b000110 ? OP_SRLV : OP_SRAV;
          alusel = RES_SHIFT;
          rd_en = 2'b11;
          wreg = 1'b1;
          iv = 1'b1;
        end
        6'b000000, 6'b000010, 6'b000011: if (inst_i[31:21] == 11'd0) begin
          aluop = funct == 6'b000000 ? OP_SLL : funct == 6'b000010 ? OP_SRL : OP_SRA;
          alusel = RES_SHIFT;
          rd_en = 2'b10;
          imm = DATA_W'(inst_i[10:6]);
          wreg = 1'b1;
          iv = 1'b1;
        end
        default: ;
      endcase
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        aluop = op == 6'b001100 ? OP_AND : op == 6'b001110 ? OP_XOR : OP_OR;
        alusel = RES_LOGIC;
        rd_en = 2'b01;
        imm = op == 6'b001111 ? DATA_W'({inst_i[15:0], 16'h0}) : DATA_W'(inst_i[15:0]);
        wd = ADDR_W'(inst_i[20:16]);
        wreg = 1'b1;
        iv = 1'b1;
      end
      6'b110011: iv = 1'b1;
      default: ;
    endcase
  end
  // Scan oldest to youngest so the youngest matching source wins, including its pending flag
  always_comb begin
    opnd = rdata;
    pend = 2'b00;
    for (int p = 0; p < 2; p++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--)
        if (fwd_wreg_i[k] && fwd_wd_i[k*ADDR_W +: ADDR_W] == addr[p]) begin
          opnd[p] = fwd_wdata_i[k*DATA_W +: DATA_W];
          pend[p] = fwd_pend_i[k];
        end
      if (addr[p] == '0) begin
        opnd[p] = '0;
        pend[p] = 1'b0;
      end
      if (!rd_en[p]) begin
        opnd[p] = imm;
        pend[p] = 1'b0;
      end
    end
  end
  assign stall = in_valid & |pend;
  assign in_ready = flush_i | (!stall & (!out_valid | out_ready));
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      aluop_o <= OP_NOP;
      alusel_o <= RES_NOP;
      reg1_o <= '0;
      reg2_o <= '0;
      wd_o <= '0;
      wreg_o <= 1'b0;
      pc_o <= '0;
      instvalid_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (stall && !flush_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_i) out_valid <= 1'b0;
      else if (!out_valid || out_ready) begin
        out_valid <= in_valid & !stall;
        aluop_o <= aluop;
        alusel_o <= alusel;
        reg1_o <= opnd[0];
        reg2_o <= opnd[1];
        wd_o <= wd;
        wreg_o <= wreg;
        pc_o <= pc_i;
        instvalid_o <= iv;
      end
    end
  end
endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: directed checks of decode, forwarding, stall, backpressure, flush and reset
module tb_id_issue_stage;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush_i = 0, out_valid, out_ready = 1;
  logic [31:0] pc_i = 0, inst_i = 0, reg1_data_i = 0, reg2_data_i = 0, reg1_o, reg2_o, pc_o;
  logic reg1_read_o, reg2_read_o, wreg_o, instvalid_o;
  logic [4:0] reg1_addr_o, reg2_addr_o, wd_o;
  logic [1:0] fwd_wreg_i = 0, fwd_pend_i = 0;
  logic [9:0] fwd_wd_i = 0;
  logic [63:0] fwd_wdata_i = 0;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic [15:0] stall_cnt_o;
  int n_cmp = 0, n_err = 0;

  id_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i), .flush_i(flush_i), .out_valid(out_valid),
    .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .instvalid_o(instvalid_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs, rt, rd, sa);
    return {6'd0, rs, rt, rd, sa, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] rs, rt, input logic [15:0] im);
    return {o, rs, rt, im};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_aluop"}, 32'(aluop_o), 0);
    chk({tag, "_alusel"}, 32'(alusel_o), 0);
    chk({tag, "_reg1"}, reg1_o, 0);
    chk({tag, "_reg2"}, reg2_o, 0);
    chk({tag, "_wd"}, 32'(wd_o), 0);
    chk({tag, "_wreg"}, 32'(wreg_o), 0);
    chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_iv"}, 32'(instvalid_o), 0);
    chk({tag, "_cnt"}, 32'(stall_cnt_o), 0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset("rst");
    rst = 0;
    in_valid = 1;
    pc_i = 32'h100;
    inst_i = itype(6'b001101, 5'd0, 5'd2, 16'h1234);
    reg1_data_i = 32'hDEAD;
    #1;
    chk("ori_rd1", 32'(reg1_read_o), 1);
    chk("ori_rd2", 32'(reg2_read_o), 0);
    chk("ori_rdy", 32'(in_ready), 1);
    tick();
    chk("ori_valid", 32'(out_valid), 1);
    chk("ori_reg1", reg1_o, 0);
    chk("ori_reg2", reg2_o, 32'h1234);
    chk("ori_wd", 32'(wd_o), 2);
    chk("ori_wreg", 32'(wreg_o), 1);
    chk("ori_aluop", 32'(aluop_o), 32'h25);
    chk("ori_alusel", 32'(alusel_o), 1);
    chk("ori_pc", pc_o, 32'h100);
    chk("ori_iv", 32'(instvalid_o), 1);
    // youngest source wins over older one for the same register
    pc_i = 32'h104;
    inst_i = rtype(6'b100101, 5'd3, 5'd4, 5'd5, 5'd0);
    reg1_data_i = 32'h111;
    reg2_data_i = 32'h222;
    fwd_wreg_i = 2'b11;
    fwd_wd_i = {5'd3, 5'd3};
    fwd_wdata_i = {32'hB, 32'hA};
    tick();
    chk("or_reg1", reg1_o, 32'hA);
    chk("or_reg2", reg2_o, 32'h222);
    chk("or_wd", 32'(wd_o), 5);
    pc_i = 32'h108;
    inst_i = rtype(6'b100100, 5'd4, 5'd3, 5'd6, 5'd0);
    fwd_wd_i = {5'd4, 5'd9};
    fwd_wdata_i = {32'hC, 32'h99};
    tick();
    chk("and_reg1", reg1_o, 32'hC);
    chk("and_reg2", reg2_o, 32'h222);
    chk("and_aluop", 32'(aluop_o), 32'h24);
    // load-use stall for two cycles
    pc_i = 32'h10C;
    inst_i = rtype(6'b100111, 5'd3, 5'd0, 5'd8, 5'd0);
    fwd_wreg_i = 2'b01;
    fwd_wd_i = {5'd0, 5'd3};
    fwd_pend_i = 2'b01;
    #1;
    chk("stall_rdy0", 32'(in_ready), 0);
    tick();
    chk("stall_bubble0", 32'(out_valid), 0);
    chk("stall_cnt1", 32'(stall_cnt_o), 1);
    chk("stall_rdy1", 32'(in_ready), 0);
    tick();
    chk("stall_bubble1", 32'(out_valid), 0);
    chk("stall_cnt2", 32'(stall_cnt_o), 2);
    fwd_pend_i = 2'b00;
    fwd_wdata_i = {32'h0, 32'h77};
    #1;
    chk("stall_rdy2", 32'(in_ready), 1);
    tick();
    chk("nor_valid", 32'(out_valid), 1);
    chk("nor_reg1", reg1_o, 32'h77);
    chk("nor_reg2", reg2_o, 0);
    chk("nor_aluop", 32'(aluop_o), 32'h27);
    chk("nor_cnt", 32'(stall_cnt_o), 2);
    // younger non-pending match shadows older pending one
    pc_i = 32'h110;
    inst_i = rtype(6'b100110, 5'd3, 5'd0, 5'd5, 5'd0);
    fwd_wreg_i = 2'b11;
    fwd_wd_i = {5'd3, 5'd3};
    fwd_wdata_i = {32'h66, 32'h55};
    fwd_pend_i = 2'b10;
    #1;
    chk("shadow_rdy", 32'(in_ready), 1);
    tick();
    chk("shadow_reg1", reg1_o, 32'h55);
    chk("shadow_aluop", 32'(aluop_o), 32'h26);
    // r0 is never forwarded and never stalls
    pc_i = 32'h114;
    inst_i = itype(6'b001101, 5'd0, 5'd1, 16'h0);
    fwd_wreg_i = 2'b01;
    fwd_wd_i = 10'd0;
    fwd_wdata_i = {32'h0, 32'hFF};
    fwd_pend_i = 2'b01;
    #1;
    chk("r0_rdy", 32'(in_ready), 1);
    tick();
    chk("r0_reg1", reg1_o, 0);
    chk("r0_valid", 32'(out_valid), 1);
    fwd_wreg_i = 0;
    fwd_pend_i = 0;
    pc_i = 32'h118;
    inst_i = rtype(6'b000000, 5'd0, 5'd2, 5'd1, 5'd5);
    reg2_data_i = 32'h3C;
    #1;
    chk("sll_rd1", 32'(reg1_read_o), 0);
    chk("sll_addr2", 32'(reg2_addr_o), 2);
    tick();
    chk("sll_reg1", reg1_o, 5);
    chk("sll_reg2", reg2_o, 32'h3C);
    chk("sll_aluop", 32'(aluop_o), 32'h7C);
    chk("sll_alusel", 32'(alusel_o), 2);
    chk("sll_wd", 32'(wd_o), 1);
    pc_i = 32'h11C;
    inst_i = itype(6'b001111, 5'd0, 5'd7, 16'hABCD);
    tick();
    chk("lui_reg2", reg2_o, 32'hABCD0000);
    chk("lui_wd", 32'(wd_o), 7);
    pc_i = 32'h200;
    inst_i = 32'hFC00_0000;
    tick();
    chk("inv_valid", 32'(out_valid), 1);
    chk("inv_iv", 32'(instvalid_o), 0);
    chk("inv_wreg", 32'(wreg_o), 0);
    chk("inv_aluop", 32'(aluop_o), 0);
    // backpressure holds the register
    out_ready = 0;
    pc_i = 32'h204;
    inst_i = itype(6'b001101, 5'd0, 5'd2, 16'h5);
    #1;
    chk("bp_rdy", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", pc_o, 32'h200);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_iv", 32'(instvalid_o), 0);
    end
    out_ready = 1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 1);
    tick();
    chk("bp_rel_pc", pc_o, 32'h204);
    chk("bp_rel_reg2", reg2_o, 5);
    chk("bp_rel_iv", 32'(instvalid_o), 1);
    // flush during a stall
    pc_i = 32'h208;
    inst_i = rtype(6'b100101, 5'd3, 5'd0, 5'd5, 5'd0);
    fwd_wreg_i = 2'b01;
    fwd_wd_i = {5'd0, 5'd3};
    fwd_pend_i = 2'b01;
    flush_i = 1;
    #1;
    chk("fl_rdy", 32'(in_ready), 1);
    tick();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_cnt", 32'(stall_cnt_o), 2);
    flush_i = 0;
    #1;
    chk("fl_stall_rdy", 32'(in_ready), 0);
    tick();
    chk("fl_cnt3", 32'(stall_cnt_o), 3);
    chk("fl_valid2", 32'(out_valid), 0);
    // reset mid-stream
    fwd_wreg_i = 0;
    fwd_pend_i = 0;
    pc_i = 32'h300;
    inst_i = itype(6'b001101, 5'd0, 5'd2, 16'h1234);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1;
    tick();
    chk_reset("mid_rst");
    rst = 0;
    in_valid = 0;
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
